// File: rtl/spi_gen_pkg.sv
// Shared types and constants for the SPI test-traffic generator.
// State encoding, pattern mode codes and the default LFSR tap mask.
package spi_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_CNT   = 2'd0;
  localparam logic [1:0] MODE_LFSR  = 2'd1;
  localparam logic [1:0] MODE_WALK  = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

  localparam logic [31:0] DEF_LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/spi_pattern_core.sv
// Pattern register: seeds on request and advances one step per accepted word.
// Kept standalone so a loopback checker can regenerate the same sequence.
module spi_pattern_core
  import spi_gen_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  LFSR_TAPS = DATA_W'(DEF_LFSR_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed,
  input  logic              adv,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] const_val,
  output logic [DATA_W-1:0] pat
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] seed_val;
  logic [DATA_W-1:0] nxt;

  always_comb begin
    seed_val = '0;
    unique case (mode)
      MODE_CNT:   seed_val = '0;
      MODE_LFSR:  seed_val = ONE;
      MODE_WALK:  seed_val = ONE;
      MODE_CONST: seed_val = const_val;
      default:    seed_val = '0;
    endcase
  end

  // Galois LFSR in right-shift form: taps fold in when the LSB shifts out
  always_comb begin
    nxt = pat;
    unique case (mode)
      MODE_CNT:   nxt = pat + ONE;
      MODE_LFSR:  nxt = pat[0] ? ((pat >> 1) ^ LFSR_TAPS)
                               : (pat >> 1);
      MODE_WALK:  nxt = {pat[DATA_W-2:0], pat[DATA_W-1]};
      MODE_CONST: nxt = pat;
      default:    nxt = pat;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat <= '0;
    end else if (seed) begin
      pat <= seed_val;
    end else if (adv) begin
      pat <= nxt;
    end
  end

endmodule

// File: rtl/spi_pattern_gen.sv
// Burst traffic generator for fifo_spi: power-of-two gaps, pattern bursts,
// backpressure-safe writes and a scope tick on every burst start.
module spi_pattern_gen
  import spi_gen_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                BURST_W   = 8,
  parameter int                DLY_EXP_W = 5,
  parameter int                DLY_BASE  = 8,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(DEF_LFSR_TAPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [1:0]           mode,
  input  logic [DATA_W-1:0]    const_val,
  input  logic [DLY_EXP_W-1:0] dly_exp,
  input  logic [BURST_W-1:0]   burst_len,
  input  logic                 fifo_full,
  output logic                 we,
  output logic [DATA_W-1:0]    din,
  output logic                 tick,
  output logic                 busy,
  output logic [DATA_W-1:0]    word_cnt
);

  localparam int MAX_EXP = DATA_W - 1;
  localparam logic [DATA_W-1:0]  ONE_D = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] ONE_B = {{(BURST_W-1){1'b0}}, 1'b1};

  state_e               state;
  state_e               state_n;
  logic [1:0]           mode_q;
  logic [DLY_EXP_W-1:0] dly_q;
  logic [BURST_W-1:0]   blen_q;
  logic [BURST_W-1:0]   blen_eff;
  logic [BURST_W-1:0]   rem;
  logic [DATA_W-1:0]    dly_cnt;
  logic [DATA_W-1:0]    limit;
  logic                 was_issue;
  logic                 start_run;
  logic                 last_word;
  logic [1:0]           core_mode;
  int                   exp_sum;

  assign start_run = (state == S_IDLE) && start;
  assign last_word = we && (rem == ONE_B);
  assign blen_eff  = (burst_len == '0) ? ONE_B : burst_len;
  assign core_mode = start_run ? mode : mode_q;

  // Gap exponent saturates so the shift never leaves the word
  always_comb begin
    exp_sum = DLY_BASE + int'(dly_q);
    if (exp_sum > MAX_EXP) exp_sum = MAX_EXP;
    limit = ONE_D << exp_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (start) state_n = S_DELAY;
      S_DELAY:
        if (stop)                          state_n = S_IDLE;
        else if (dly_cnt == limit - ONE_D) state_n = S_ISSUE;
      S_ISSUE:
        if (last_word) state_n = stop ? S_IDLE : S_DELAY;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_comb begin
    we   = 1'b0;
    tick = 1'b0;
    busy = 1'b1;
    unique case (1'b1)
      (state == S_IDLE):  busy = 1'b0;
      (state == S_DELAY): busy = 1'b1;
      (state == S_ISSUE): begin
        we   = !fifo_full;
        tick = !was_issue;
      end
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_CNT;
      dly_q     <= '0;
      blen_q    <= '0;
      rem       <= '0;
      dly_cnt   <= '0;
      word_cnt  <= '0;
      was_issue <= 1'b0;
    end else begin
      was_issue <= (state == S_ISSUE);
      dly_cnt   <= (state == S_DELAY && state_n == S_DELAY)
                   ? dly_cnt + ONE_D : '0;
      if (start_run) begin
        mode_q   <= mode;
        dly_q    <= dly_exp;
        blen_q   <= blen_eff;
        rem      <= blen_eff;
        word_cnt <= '0;
      end else if (we) begin
        word_cnt <= word_cnt + ONE_D;
        rem      <= (rem == ONE_B) ? blen_q : rem - ONE_B;
      end
    end
  end

  spi_pattern_core #(
    .DATA_W    (DATA_W),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .seed      (start_run),
    .adv       (we),
    .mode      (core_mode),
    .const_val (const_val),
    .pat       (din)
  );

endmodule

// File: tb/tb_spi_pattern_gen.sv
// Bench for spi_pattern_gen: run-level reference model checked every cycle
// plus directed literal expectations for each scenario.
module tb_spi_pattern_gen;

  localparam int DW = 32;
  localparam int DB = 2;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic [DW-1:0] const_val;
  logic [4:0]    dly_exp;
  logic [7:0]    burst_len;
  logic          fifo_full;
  logic          we;
  logic [DW-1:0] din;
  logic          tick;
  logic          busy;
  logic [DW-1:0] word_cnt;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int start_cyc;
  int first_tick_cyc;
  int n_tick;
  logic [31:0] got[$];

  spi_pattern_gen #(.DLY_BASE(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .const_val (const_val),
    .dly_exp   (dly_exp),
    .burst_len (burst_len),
    .fifo_full (fifo_full),
    .we        (we),
    .din       (din),
    .tick      (tick),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] p,
                                      input logic [1:0] m);
    case (m)
      2'd0:    return p + 32'd1;
      2'd1:    return p[0] ? ((p >> 1) ^ TAPS) : (p >> 1);
      2'd2:    return (p == 32'h8000_0000) ? 32'd1 : (p << 1);
      default: return p;
    endcase
  endfunction

  // Reference model: run phase, gap length, words left and next pattern word
  int          m_phase;
  longint      m_gap;
  longint      m_lim;
  int          m_rem;
  int          m_blen;
  logic        m_first;
  logic [1:0]  m_mode;
  logic [31:0] m_pat;
  logic [31:0] m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_gap = 0; m_rem = 0; m_first = 0;
      m_pat = 0; m_cnt = 0; m_mode = 0; m_lim = 1; m_blen = 1;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_mode = mode;
          m_blen = (burst_len == 0) ? 1 : int'(burst_len);
          m_rem  = m_blen;
          m_lim  = longint'(1) << ((DB + dly_exp > 31) ? 31 : DB + dly_exp);
          m_gap  = m_lim;
          m_cnt  = 0;
          m_pat  = (mode == 2'd0) ? 32'd0 :
                   (mode == 2'd3) ? const_val : 32'd1;
          m_phase = 1;
        end
        1: if (stop) m_phase = 0;
           else begin
             m_gap--;
             if (m_gap == 0) begin m_phase = 2; m_first = 1; end
           end
        default: begin
          m_first = 0;
          if (!fifo_full) begin
            m_pat = nxt(m_pat, m_mode);
            m_cnt++;
            m_rem--;
            if (m_rem == 0) begin
              if (stop) m_phase = 0;
              else begin m_phase = 1; m_gap = m_lim; m_rem = m_blen; end
            end
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 64'(busy), 64'(m_phase != 0));
      chk("we", 64'(we), 64'(m_phase == 2 && !fifo_full));
      chk("tick", 64'(tick), 64'(m_phase == 2 && m_first));
      chk("word_cnt", 64'(word_cnt), 64'(m_cnt));
      if (m_phase == 2) chk("din", 64'(din), 64'(m_pat));
      if (we) got.push_back(din);
      if (tick) begin
        n_tick++;
        if (first_tick_cyc < 0) first_tick_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [1:0] md, input logic [31:0] cv,
                    input logic [4:0] de, input logic [7:0] bl);
    got.delete();
    n_tick = 0;
    first_tick_cyc = -1;
    mode = md; const_val = cv; dly_exp = de; burst_len = bl;
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    mode = 2'd0; const_val = '0; dly_exp = '0; burst_len = '0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin step(); k++; end
    if (got.size() < n) begin
      n_run++; n_fail++;
      $display("FAIL timeout: %0d words seen, %0d required", got.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin step(); k++; end
    chk("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic chk_word(input string nm, input int idx,
                          input logic [31:0] exp);
    if (idx >= got.size()) chk(nm, 64'hDEAD_0000_0000, 64'(exp));
    else                   chk(nm, 64'(got[idx]), 64'(exp));
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 0; stop = 0; mode = 0; const_val = 0;
    dly_exp = 0; burst_len = 0; fifo_full = 0;
    n_tick = 0; first_tick_cyc = -1;
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_tick", 64'(tick), 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    rst = 1'b0;
    step();

    // counter bursts of 4, gap 4, stop requested inside second burst
    go(2'd0, 32'd0, 5'd0, 8'd4);
    wait_words(5, 100);
    stop = 1'b1;
    wait_idle(100);
    stop = 1'b0;
    chk("cnt_words", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk_word("cnt_din", i, 32'(i));
    chk("cnt_ticks", 64'(n_tick), 64'd2);
    chk("cnt_tick_latency", 64'(first_tick_cyc - start_cyc), 64'd5);
    chk("cnt_word_cnt", 64'(word_cnt), 64'd8);

    // LFSR sequence from seed 1
    go(2'd1, 32'd0, 5'd0, 8'd3);
    wait_words(1, 100);
    stop = 1'b1;
    wait_idle(100);
    stop = 1'b0;
    chk("lfsr_words", 64'(got.size()), 64'd3);
    chk_word("lfsr0", 0, 32'h0000_0001);
    chk_word("lfsr1", 1, 32'h8020_0003);
    chk_word("lfsr2", 2, 32'hC030_0002);

    // walking one wraps back to 1 after DATA_W words
    go(2'd2, 32'd0, 5'd0, 8'd33);
    wait_words(1, 100);
    stop = 1'b1;
    wait_idle(200);
    stop = 1'b0;
    chk("walk_words", 64'(got.size()), 64'd33);
    chk_word("walk0", 0, 32'h0000_0001);
    chk_word("walk5", 5, 32'h0000_0020);
    chk_word("walk31", 31, 32'h8000_0000);
    chk_word("walk32", 32, 32'h0000_0001);

    // five-cycle backpressure stall mid-burst
    go(2'd0, 32'd0, 5'd0, 8'd8);
    wait_words(3, 100);
    fifo_full = 1'b1;
    repeat (5) step();
    chk("stall_words_held", 64'(got.size()), 64'd3);
    chk("stall_din_held", 64'(din), 64'd3);
    fifo_full = 1'b0;
    stop = 1'b1;
    wait_idle(100);
    stop = 1'b0;
    chk("stall_words", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk_word("stall_din", i, 32'(i));
    chk("stall_word_cnt", 64'(word_cnt), 64'd8);

    // burst_len 0 acts as single-word bursts, constant pattern
    go(2'd3, 32'hA5A5_5A5A, 5'd0, 8'd0);
    wait_words(2, 100);
    stop = 1'b1;
    wait_idle(100);
    stop = 1'b0;
    chk("single_words", 64'(got.size()), 64'd2);
    chk_word("const0", 0, 32'hA5A5_5A5A);
    chk_word("const1", 1, 32'hA5A5_5A5A);
    chk("single_ticks", 64'(n_tick), 64'd2);

    // gap limit: unclamped and clamped exponents, stop honoured in the gap
    go(2'd0, 32'd0, 5'd3, 8'd1);
    chk("limit_exp5", 64'(dut.limit), 64'h20);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_delay_busy", 64'(busy), 64'd0);
    go(2'd0, 32'd0, 5'd31, 8'd0);
    chk("limit_clamp", 64'(dut.limit), 64'h8000_0000);
    chk("clamp_busy", 64'(busy), 64'd1);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_clamp_busy", 64'(busy), 64'd0);
    chk("stop_clamp_words", 64'(got.size()), 64'd0);

    // asynchronous reset while a word is being written
    go(2'd0, 32'd0, 5'd0, 8'd8);
    k = 0;
    while (!we && k < 50) begin step(); k++; end
    chk("pre_reset_we", 64'(we), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_we", 64'(we), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_word_cnt", 64'(word_cnt), 64'd0);
    step();
    rst = 1'b0;
    got.delete();
    repeat (12) step();
    chk("post_reset_words", 64'(got.size()), 64'd0);
    chk("post_reset_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
